// File: rtl/video_fetch_pkg.sv
// Shared sizing defaults and the {attr, pix} pair layout for the video fetch block.
package video_fetch_pkg;

    localparam int VF_DEPTH          = 8;
    localparam int VF_WORDS_PER_LINE = 32;

    // attr sits in bits [31:16], pix in bits [15:0]
    typedef struct packed {
        logic [15:0] attr;
        logic [15:0] pix;
    } vf_pair_t;

    function automatic vf_pair_t vf_make_pair(input logic [15:0] pix, input logic [15:0] attr);
        vf_pair_t p;
        p.attr = attr;
        p.pix  = pix;
        return p;
    endfunction

endpackage

// File: rtl/video_fetch_fifo.sv
// Register-array word FIFO: single-word write, double-word pop, two-word head read.
module video_fetch_fifo #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    input  logic        pop2,
    output logic [15:0] head_lo,
    output logic [15:0] head_hi
);
    localparam int AW = $clog2(DEPTH);

    logic [15:0]   mem_reg [DEPTH];
    logic [AW-1:0] head_reg, head_next;
    logic [AW-1:0] tail_reg, tail_next;
    logic [AW-1:0] head_inc;

    always_comb begin
        head_next = head_reg;
        tail_next = tail_reg;
        if (flush) begin
            head_next = '0;
            tail_next = '0;
        end else begin
            if (wr_en)
                tail_next = tail_reg + AW'(1);
            if (pop2)
                head_next = head_reg + AW'(2);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg <= '0;
            tail_reg <= '0;
        end else begin
            head_reg <= head_next;
            tail_reg <= tail_next;
        end
    end

    // Storage carries no reset; the top gates pair_data with pair_valid.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
        always_ff @(posedge clk) begin
            if (wr_en && !flush && tail_reg == AW'(gi))
                mem_reg[gi] <= wr_data;
        end
    end

    assign head_inc = head_reg + AW'(1);
    assign head_lo  = mem_reg[head_reg];
    assign head_hi  = mem_reg[head_inc];

endmodule

// File: rtl/video_fetch.sv
// Per-line DRAM fetch: issues requests within the window, tracks credit, pairs returned words.
module video_fetch
    import video_fetch_pkg::*;
#(
    parameter int DEPTH          = VF_DEPTH,
    parameter int WORDS_PER_LINE = VF_WORDS_PER_LINE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_start,
    input  logic        int_start,
    output logic        video_go,
    input  logic        video_next,
    input  logic        video_strobe,
    input  logic [15:0] video_data,
    input  logic        pair_pop,
    output logic        pair_valid,
    output logic [31:0] pair_data,
    output logic        overrun
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int LW = $clog2(WORDS_PER_LINE) + 1;

    logic          win_reg, win_next;
    logic [LW-1:0] left_reg, left_next;
    logic [CW-1:0] outst_reg, outst_next;
    logic [CW-1:0] fill_reg, fill_next;
    logic [CW-1:0] discard_reg, discard_next;
    logic          overrun_reg, overrun_next;

    logic [CW:0]   credit_sum;
    logic [CW:0]   flush_sum;
    logic          accept, pop, wr, strobe_drop, strobe_err, strobe_owed;
    logic [15:0]   head_lo, head_hi;
    vf_pair_t      head_pair;

    assign credit_sum  = {1'b0, fill_reg} + {1'b0, outst_reg};
    assign video_go    = win_reg && (left_reg != '0) && (credit_sum < (CW+1)'(DEPTH));
    assign accept      = video_next && video_go;
    assign pair_valid  = fill_reg >= CW'(2);
    assign pop         = pair_pop && pair_valid;
    assign strobe_drop = video_strobe && (discard_reg != '0);
    assign strobe_owed = video_strobe && (discard_reg == '0);
    assign wr          = strobe_owed && (outst_reg != '0);
    assign strobe_err  = strobe_owed && (outst_reg == '0);

    // Words still in flight at a flush must be dropped when they come back.
    always_comb begin
        flush_sum = {1'b0, outst_reg} + (CW+1)'(accept);
        if (strobe_owed && flush_sum != '0)
            flush_sum = flush_sum - (CW+1)'(1);
    end

    always_comb begin
        win_next     = win_reg;
        left_next    = left_reg;
        outst_next   = outst_reg;
        fill_next    = fill_reg;
        discard_next = discard_reg;
        overrun_next = overrun_reg;
        if (int_start) begin
            win_next     = 1'b0;
            left_next    = '0;
            outst_next   = '0;
            fill_next    = '0;
            discard_next = flush_sum[CW-1:0];
            overrun_next = 1'b0;
        end else begin
            if (fetch_start) begin
                win_next  = 1'b1;
                left_next = LW'(WORDS_PER_LINE);
            end else if (accept) begin
                left_next = left_reg - LW'(1);
                if (left_reg == LW'(1))
                    win_next = 1'b0;
            end
            outst_next   = outst_reg + CW'(accept) - CW'(wr);
            fill_next    = fill_reg + CW'(wr) - (pop ? CW'(2) : CW'(0));
            discard_next = discard_reg - CW'(strobe_drop);
            overrun_next = overrun_reg | (video_next && !video_go) | strobe_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_reg     <= 1'b0;
            left_reg    <= '0;
            outst_reg   <= '0;
            fill_reg    <= '0;
            discard_reg <= '0;
            overrun_reg <= 1'b0;
        end else begin
            win_reg     <= win_next;
            left_reg    <= left_next;
            outst_reg   <= outst_next;
            fill_reg    <= fill_next;
            discard_reg <= discard_next;
            overrun_reg <= overrun_next;
        end
    end

    video_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (int_start),
        .wr_en   (wr && !int_start),
        .wr_data (video_data),
        .pop2    (pop && !int_start),
        .head_lo (head_lo),
        .head_hi (head_hi)
    );

    assign head_pair = vf_make_pair(head_lo, head_hi);
    assign pair_data = pair_valid ? head_pair : '0;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_video_fetch.sv
// Directed bench for video_fetch: nominal line, back-pressure, combined events, flush, errors, reset.
module tb_video_fetch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_start = 1'b0;
    logic        int_start = 1'b0;
    logic        video_go;
    logic        video_next = 1'b0;
    logic        video_strobe = 1'b0;
    logic [15:0] video_data = '0;
    logic        pair_pop = 1'b0;
    logic        pair_valid;
    logic [31:0] pair_data;
    logic        overrun;

    int total = 0;
    int bad   = 0;

    video_fetch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch_start  (fetch_start),
        .int_start    (int_start),
        .video_go     (video_go),
        .video_next   (video_next),
        .video_strobe (video_strobe),
        .video_data   (video_data),
        .pair_pop     (pair_pop),
        .pair_valid   (pair_valid),
        .pair_data    (pair_data),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-16s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic nx, input logic st, input logic pp, input logic [15:0] d);
        video_next   = nx;
        video_strobe = st;
        pair_pop     = pp;
        video_data   = d;
        tick();
        video_next   = 1'b0;
        video_strobe = 1'b0;
        pair_pop     = 1'b0;
    endtask

    task automatic pulse_fetch();
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
    endtask

    task automatic pulse_int();
        int_start = 1'b1;
        tick();
        int_start = 1'b0;
    endtask

    initial begin
        int          gap, nexts, pairs;
        logic [15:0] wcnt, pidx;
        logic [3:0]  pipe;

        // Reset values
        #12;
        chk("rst_go", 32'(video_go), 32'd0);
        chk("rst_valid", 32'(pair_valid), 32'd0);
        chk("rst_data", pair_data, 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Nominal line: grant every 4 clocks, strobe 3 clocks after grant, pop at once
        pulse_fetch();
        chk("go_after_start", 32'(video_go), 32'd1);
        gap = 0; nexts = 0; pairs = 0; wcnt = '0; pidx = '0; pipe = '0;
        for (int c = 0; c < 150; c++) begin
            video_next   = video_go && (gap == 0);
            video_strobe = pipe[2];
            video_data   = 16'hA000 + wcnt;
            if (pipe[2]) wcnt = wcnt + 16'd1;
            pair_pop = pair_valid;
            if (pair_valid) begin
                chk("nom_pair", pair_data, {16'hA001 + pidx, 16'hA000 + pidx});
                pidx  = pidx + 16'd2;
                pairs++;
            end
            if (video_next) begin
                nexts++;
                gap = 3;
            end else if (gap > 0) begin
                gap--;
            end
            pipe = {pipe[2:0], video_next};
            tick();
            if (video_next && nexts == 32)
                chk("nom_go_end", 32'(video_go), 32'd0);
        end
        video_next = 1'b0; video_strobe = 1'b0; pair_pop = 1'b0;
        chk("nom_nexts", 32'(nexts), 32'd32);
        chk("nom_pairs", 32'(pairs), 32'd16);
        chk("nom_overrun", 32'(overrun), 32'd0);

        // Back-pressure: immediate grants, no pops
        pulse_fetch();
        nexts = 0; wcnt = '0; pipe = '0;
        for (int c = 0; c < 20; c++) begin
            video_next   = video_go;
            video_strobe = pipe[2];
            video_data   = 16'hB000 + wcnt;
            if (pipe[2]) wcnt = wcnt + 16'd1;
            if (video_next) nexts++;
            pipe = {pipe[2:0], video_next};
            tick();
        end
        video_next = 1'b0; video_strobe = 1'b0;
        chk("bp_nexts", 32'(nexts), 32'd8);
        chk("bp_go_low", 32'(video_go), 32'd0);
        chk("bp_valid", 32'(pair_valid), 32'd1);
        chk("bp_head", pair_data, 32'hB001_B000);
        step(1'b0, 1'b0, 1'b1, 16'h0);
        chk("bp_go_rise", 32'(video_go), 32'd1);
        nexts = 0;
        for (int c = 0; c < 12; c++) begin
            video_next   = video_go;
            video_strobe = pipe[2];
            video_data   = 16'hB000 + wcnt;
            if (pipe[2]) wcnt = wcnt + 16'd1;
            if (video_next) nexts++;
            pipe = {pipe[2:0], video_next};
            tick();
        end
        video_next = 1'b0; video_strobe = 1'b0;
        chk("bp_more_nexts", 32'(nexts), 32'd2);
        chk("bp_head2", pair_data, 32'hB003_B002);
        pulse_int();
        chk("bp_flush_valid", 32'(pair_valid), 32'd0);
        chk("bp_flush_go", 32'(video_go), 32'd0);

        // Simultaneous next + strobe + pop at fill=3, outst=2
        pulse_fetch();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 16'hC000 + 16'(i));
        chk("sim_pre_head", pair_data, 32'hC001_C000);
        step(1'b1, 1'b1, 1'b1, 16'hC003);
        chk("sim_fill", 32'(dut.fill_reg), 32'd2);
        chk("sim_outst", 32'(dut.outst_reg), 32'd2);
        chk("sim_left", 32'(dut.left_reg), 32'd26);
        chk("sim_head", pair_data, 32'hC003_C002);

        // int_start with outst=3, fill=5
        step(1'b0, 1'b1, 1'b0, 16'hC004);
        step(1'b0, 1'b1, 1'b0, 16'hC005);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 16'h0);
        chk("fl_go_full", 32'(video_go), 32'd0);
        step(1'b0, 1'b1, 1'b0, 16'hC006);
        pulse_int();
        chk("fl_valid", 32'(pair_valid), 32'd0);
        chk("fl_discard", 32'(dut.discard_reg), 32'd3);
        pulse_fetch();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 16'hDEAD);
        chk("fl_drop_valid", 32'(pair_valid), 32'd0);
        chk("fl_drop_fill", 32'(dut.fill_reg), 32'd0);
        chk("fl_drop_ovr", 32'(overrun), 32'd0);
        step(1'b1, 1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b1, 1'b0, 16'h1111);
        step(1'b0, 1'b1, 1'b0, 16'h2222);
        chk("fl_new_pair", pair_data, 32'h2222_1111);
        step(1'b0, 1'b0, 1'b1, 16'h0);
        pulse_int();

        // Protocol errors
        step(1'b1, 1'b0, 1'b0, 16'h0);
        chk("pe_next_ovr", 32'(overrun), 32'd1);
        chk("pe_next_outst", 32'(dut.outst_reg), 32'd0);
        chk("pe_next_left", 32'(dut.left_reg), 32'd0);
        step(1'b0, 1'b1, 1'b0, 16'h5555);
        chk("pe_strb_fill", 32'(dut.fill_reg), 32'd0);
        chk("pe_strb_outst", 32'(dut.outst_reg), 32'd0);
        tick(); tick(); tick();
        chk("pe_sticky", 32'(overrun), 32'd1);
        pulse_int();
        chk("pe_cleared", 32'(overrun), 32'd0);

        // Async reset mid-line
        pulse_fetch();
        step(1'b1, 1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b1, 1'b0, 16'h7777);
        step(1'b0, 1'b1, 1'b0, 16'h8888);
        step(1'b0, 1'b1, 1'b0, 16'h9999);
        chk("ar_pre_go", 32'(video_go), 32'd1);
        chk("ar_pre_data", pair_data, 32'h8888_7777);
        chk("ar_pre_ovr", 32'(overrun), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_go", 32'(video_go), 32'd0);
        chk("ar_valid", 32'(pair_valid), 32'd0);
        chk("ar_data", pair_data, 32'd0);
        chk("ar_ovr", 32'(overrun), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/video_fetch.md
# video_fetch

Downstream neighbour of the video address generator: issues read requests to the DRAM arbiter during the per-line fetch window, counts the words the arbiter has accepted but not yet returned, and buffers the returned 16-bit words. It presents them to the pixel renderer as {attr, pix} word pairs. It is the only place where fetch-window length and buffer credit are tracked.

## Interface
Parameters:
- DEPTH, 8 — word FIFO depth; even, power of two, 4..16.
- WORDS_PER_LINE, 32 — words requested per fetch window (16 pix + 16 attr in zx mode).

Ports:
- clk  in  1  28 MHz clock; one clock domain.
- rst_n  in  1  reset, asynchronous assert, active-low.
- fetch_start  in  1  one-cycle pulse, opens the fetch window.
- int_start  in  1  one-cycle pulse, frame start; flushes the block.
- video_go  out  1  request to the arbiter; combinational from registers.
- video_next  in  1  arbiter accepted one request (address consumed).
- video_strobe  in  1  read data valid on video_data.
- video_data  in  16  DRAM read word.
- pair_pop  in  1  renderer consumes the head pair.
- pair_valid  out  1  a full {attr, pix} pair is at the head.
- pair_data  out  32  {attr_word, pix_word}; valid only while pair_valid.
- overrun  out  1  sticky error flag; cleared only by reset or int_start.

## Operation
- State:
  - win (window open)
  - left (0..WORDS_PER_LINE, requests still to issue)
  - outst (0..DEPTH, accepted but not yet returned)
  - fill (0..DEPTH, words in FIFO)
  - discard (0..DEPTH, returns to drop)
- video_go = win && left != 0 && (fill + outst) < DEPTH. The sum is computed 1 bit wider than log2(DEPTH)+1.
- fetch_start: win <= 1, left <= WORDS_PER_LINE. If the window is already open, it restarts with left reloaded; fill and outst are kept.
- video_next with video_go high: left -= 1, outst += 1. When left reaches 0, win <= 0.
- video_next with video_go low: ignored for all counters; sets overrun.
- video_strobe:
  - discard != 0: decrement discard; the word is dropped.
  - otherwise: the word is written at the FIFO tail, fill += 1, outst -= 1.
  - outst == 0 and discard == 0: the word is dropped and overrun is set.
- Pairing: words alternate pix then attr, starting with pix after every fetch_start, because WORDS_PER_LINE is even and pops are always 2 words. The head word at an even FIFO index is always pix.
- pair_valid = fill >= 2. pair_data = {fifo[head+1], fifo[head]}.
- pair_pop with pair_valid: head += 2, fill -= 2. pair_pop without pair_valid: ignored.
- Same-cycle events combine arithmetically:
  - strobe + pop: fill += 1 - 2.
  - next + strobe: outst unchanged.
  - All three are legal in one cycle.
- int_start, highest priority over all other inputs in the same cycle:
  - win <= 0, left <= 0, fill <= 0, head/tail <= 0.
  - discard <= outst + (video_next && video_go ? 1 : 0) - (video_strobe && discard == 0 ? 1 : 0).
  - outst <= 0, overrun <= 0.
- FIFO pointers wrap modulo DEPTH.

## Timing
- Reset values: video_go 0, pair_valid 0, pair_data 0, overrun 0. All counters and pointers are 0; win is 0.
- video_go responds combinationally to register state:
  - It is high in the cycle after fetch_start.
  - It is low in the cycle after the video_next that takes left to 0 or brings fill + outst to DEPTH.
- Strobe-to-valid latency: a word written on edge N is visible at the head from cycle N+1. pair_valid rises in the cycle after the second word of a pair is stored.
- pop-to-next-pair: registered; the next pair is valid the cycle after the pop edge if fill >= 4 before the pop.
- Buffer full (fill == DEPTH): video_go is 0, so no overflow is possible under a legal arbiter.
- Reset asserted mid-fetch: everything clears immediately. Strobes arriving after reset release are unexpected and set overrun.

## Structure
- Shared defines (include header, alongside tune.v): VF_DEPTH and VF_WORDS_PER_LINE defaults, and the pair layout with attr in bits [31:16] and pix in bits [15:0].
- One sub-module: video_fetch_fifo, a register-array FIFO with a write port, a double-word pop and a two-word head read.
- Counter and window logic stay in the top module.

## Test plan
- Nominal line: fetch_start, arbiter grants every 4 clocks with strobe 3 clocks later, renderer pops immediately. Required: exactly 32 next pulses, 16 pairs with pix/attr in order, video_go low after the 32nd next, overrun 0.
- Back-pressure: no pops, immediate grants. Required: video_go falls when fill + outst = 8. Then pop one pair: video_go rises the next cycle and exactly 2 more requests are accepted.
- Simultaneous events: video_next, video_strobe and pair_pop in one cycle at fill = 3, outst = 2. Required next state: fill = 2, outst = 2, left decremented by 1.
- int_start with outst = 3 and fill = 5. Required: pair_valid 0 next cycle and the next 3 strobes dropped. A following fetch_start line delivers its first word as pix.
- Protocol errors: video_next while video_go = 0, then a strobe with outst = 0. Required: counters unchanged, overrun = 1 until int_start.
- Async reset asserted mid-line. Required: all outputs 0 within the same cycle, without waiting for a clk edge.
